regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (we3/a3/wd3) between two writeback requesters.
- Source A is the ALU/execute writeback; source B is the load/memory writeback.
- Arbitration is fixed-priority to A, with a starvation counter that forces a B grant. Granted writes are registered before driving the port.
- Provides per-read-port hazard flags so decode can stall while a write to the register being read is still pending.

---
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing the register file's single write port between the
// ALU source (A, priority) and the load source (B, starvation-protected).
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic                  hazard1,
    output logic                  hazard2
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [3:0]            LIMIT     = 4'(STARVE_LIMIT);

    logic                  a_nz_s;
    logic                  b_nz_s;
    logic                  force_b_s;
    logic                  a_grant_s;
    logic                  b_grant_s;
    logic [3:0]            starve_cnt_d;
    logic [3:0]            starve_cnt_q;
    logic                  rf_we_d;
    logic                  rf_we_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q;

    // A read sees a pending write from either requester or the registered port write.
    function automatic logic hazard_f(
        input logic [ADDR_WIDTH-1:0] rd,
        input logic                  av,
        input logic [ADDR_WIDTH-1:0] aa,
        input logic                  bv,
        input logic [ADDR_WIDTH-1:0] ba,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] wa
    );
        return (rd != ZERO_ADDR) &&
               ((av && (aa == rd)) || (bv && (ba == rd)) || (we && (wa == rd)));
    endfunction

    // Arbitration, handshake and next-state of the write port and starvation counter.
    always_comb begin
        a_nz_s       = a_valid && (a_addr != ZERO_ADDR);
        b_nz_s       = b_valid && (b_addr != ZERO_ADDR);
        force_b_s    = (starve_cnt_q >= LIMIT);
        a_grant_s    = a_nz_s && !(b_nz_s && force_b_s);
        b_grant_s    = b_nz_s && !a_grant_s;
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        starve_cnt_d = 4'd0;

        if (rst) begin
            a_ready = 1'b0;
            b_ready = 1'b0;
        end else begin
            // Zero-address requests are sunk immediately and never reach the port.
            a_ready = a_valid && (!a_nz_s || a_grant_s);
            b_ready = b_valid && (!b_nz_s || b_grant_s);
        end

        if (a_grant_s) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = a_addr;
            rf_wdata_d = a_data;
        end else if (b_grant_s) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = b_addr;
            rf_wdata_d = b_data;
        end else begin
            rf_we_d = 1'b0;
        end

        if (b_nz_s && !b_grant_s) begin
            starve_cnt_d = (starve_cnt_q == 4'd15) ? 4'd15 : starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = 4'd0;
        end
    end

    // Registered write port and starvation counter; reset drops any in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= ZERO_ADDR;
            rf_wdata_q   <= {DATA_WIDTH{1'b0}};
            starve_cnt_q <= 4'd0;
        end else begin
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign hazard1  = hazard_f(rd_addr1, a_valid, a_addr, b_valid, b_addr, rf_we_q, rf_waddr_q);
    assign hazard2  = hazard_f(rd_addr2, a_valid, a_addr, b_valid, b_addr, rf_we_q, rf_waddr_q);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter with a small register file model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [4:0]  a_addr, b_addr, rf_waddr, rd_addr1, rd_addr2;
    logic [31:0] a_data, b_data, rf_wdata;
    logic        rf_we, hazard1, hazard2;
    logic [31:0] rf_model [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    typedef struct {
        int av; int aa; int ad;
        int bv; int ba; int bd;
        int r1; int r2;
        int ear; int ebr; int eh1; int eh2;
        int ewe; int ewa; int ewd;
    } vec_t;

    vec_t vecs [16];

    regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .hazard1(hazard1), .hazard2(hazard2)
    );

    always #5 clk = ~clk;

    // Register file as the port would commit it.
    always @(posedge clk) begin
        if (!rst && rf_we && rf_waddr != 5'd0) rf_model[rf_waddr] <= rf_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int av, input int aa, input int ad,
                         input int bv, input int ba, input int bd,
                         input int r1, input int r2);
        a_valid  = 1'(av); a_addr = 5'(aa); a_data = 32'(ad);
        b_valid  = 1'(bv); b_addr = 5'(ba); b_data = 32'(bd);
        rd_addr1 = 5'(r1); rd_addr2 = 5'(r2);
    endtask

    task automatic chk_port(input string tag, input int we, input int wa, input int wd);
        chk({tag, " rf_we"},    32'(rf_we),    32'(we));
        chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(wa));
        chk({tag, " rf_wdata"}, rf_wdata,      32'(wd));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;

        //        av aa  ad      bv ba bd      r1 r2  ar br h1 h2  we wa wd
        vecs[0]  = '{1, 5, 'h1234, 0, 0, 0,     5, 0,  1, 0, 1, 0,  1, 5, 'h1234};
        vecs[1]  = '{0, 0, 0,      0, 0, 0,     5, 5,  0, 0, 1, 1,  0, 5, 'h1234};
        vecs[2]  = '{0, 0, 0,      0, 0, 0,     5, 0,  0, 0, 0, 0,  0, 5, 'h1234};
        vecs[3]  = '{1, 0, 'h55,   1, 7, 'h77,  0, 7,  1, 1, 0, 1,  1, 7, 'h77};
        vecs[4]  = '{0, 0, 0,      0, 0, 0,     0, 12, 0, 0, 0, 0,  0, 7, 'h77};
        vecs[5]  = '{1, 12, 'hC0C, 0, 0, 0,     0, 12, 1, 0, 0, 1,  1, 12, 'hC0C};
        vecs[6]  = '{1, 0, 'h9,    0, 0, 0,     0, 12, 1, 0, 0, 1,  0, 12, 'hC0C};
        vecs[7]  = '{1, 3, 'h307,  1, 4, 'h4A1, 3, 4,  1, 0, 1, 1,  1, 3, 'h307};
        vecs[8]  = '{1, 3, 'h308,  1, 4, 'h4A1, 3, 4,  1, 0, 1, 1,  1, 3, 'h308};
        vecs[9]  = '{1, 3, 'h309,  1, 4, 'h4A1, 3, 4,  1, 0, 1, 1,  1, 3, 'h309};
        vecs[10] = '{1, 3, 'h30A,  1, 4, 'h4A1, 3, 4,  0, 1, 1, 1,  1, 4, 'h4A1};
        vecs[11] = '{1, 3, 'h30A,  1, 4, 'h4A2, 3, 4,  1, 0, 1, 1,  1, 3, 'h30A};
        vecs[12] = '{1, 3, 'h30C,  1, 4, 'h4A2, 3, 4,  1, 0, 1, 1,  1, 3, 'h30C};
        vecs[13] = '{1, 3, 'h30D,  1, 4, 'h4A2, 3, 4,  1, 0, 1, 1,  1, 3, 'h30D};
        vecs[14] = '{1, 3, 'h30E,  1, 4, 'h4A2, 3, 4,  0, 1, 1, 1,  1, 4, 'h4A2};
        vecs[15] = '{0, 0, 0,      0, 0, 0,     3, 4,  0, 0, 0, 1,  0, 4, 'h4A2};

        // Reset state, with requests presented to show ready is held low.
        rst = 1'b1;
        drive(1, 5, 'h11, 1, 6, 'h22, 0, 0);
        #2;
        chk("rst a_ready", 32'(a_ready), 32'd0);
        chk("rst b_ready", 32'(b_ready), 32'd0);
        chk_port("rst", 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba,
                  vecs[i].bd, vecs[i].r1, vecs[i].r2);
            #3;
            chk($sformatf("v%0d a_ready", i), 32'(a_ready), 32'(vecs[i].ear));
            chk($sformatf("v%0d b_ready", i), 32'(b_ready), 32'(vecs[i].ebr));
            chk($sformatf("v%0d hazard1", i), 32'(hazard1), 32'(vecs[i].eh1));
            chk($sformatf("v%0d hazard2", i), 32'(hazard2), 32'(vecs[i].eh2));
            @(posedge clk); #1;
            chk_port($sformatf("v%0d", i), vecs[i].ewe, vecs[i].ewa, vecs[i].ewd);
        end
        chk("reg5", rf_model[5], 32'h1234);
        chk("reg4", rf_model[4], 32'h4A2);

        // Same destination from both sources: A then B, B's value wins.
        drive(1, 9, 'hAA, 1, 9, 'hBB, 9, 0);
        #3;
        chk("same a_ready", 32'(a_ready), 32'd1);
        chk("same b_ready0", 32'(b_ready), 32'd0);
        chk("same hz c0", 32'(hazard1), 32'd1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk_port("same A", 1, 9, 'hAA);
        #3;
        chk("same b_ready1", 32'(b_ready), 32'd1);
        chk("same hz c1", 32'(hazard1), 32'd1);
        @(posedge clk); #1;
        b_valid = 1'b0;
        chk_port("same B", 1, 9, 'hBB);
        chk("same reg9 mid", rf_model[9], 32'hAA);
        #3;
        chk("same hz c2", 32'(hazard1), 32'd1);
        @(posedge clk); #1;
        chk("same rf_we off", 32'(rf_we), 32'd0);
        chk("same hz c3", 32'(hazard1), 32'd0);
        chk("same reg9 end", rf_model[9], 32'hBB);

        // Reset while a write is in flight.
        drive(1, 20, 'hDEAD, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("midrst pre we", 32'(rf_we), 32'd1);
        drive(1, 5, 'h1, 1, 6, 'h2, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk_port("midrst", 0, 0, 0);
        chk("midrst a_ready", 32'(a_ready), 32'd0);
        chk("midrst b_ready", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        chk("midrst hold we", 32'(rf_we), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        drive(1, 5, 'h5678, 0, 0, 0, 0, 0);
        #3;
        chk("post a_ready", 32'(a_ready), 32'd1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk_port("post w", 1, 5, 'h5678);
        @(posedge clk); #1;
        chk("post we off", 32'(rf_we), 32'd0);
        chk("post reg20", rf_model[20], 32'd0);
        chk("post reg5", rf_model[5], 32'h5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
